// File: rtl/trap_ctrl_nx.sv
// trap_ctrl_nx: machine-mode trap controller for the single-issue core.
// Sequences trap entry (mstatus/mepc/mcause/mtval writes, vector jump) and
// MRET exit over the one-port CSR bus, and keeps a small stack of trap
// records so nested external interrupts are completed in the correct order.
// Build option: define TRAP_MTVAL_EN to add the mtval write state (WTVL);
// without it the entry sequence goes WCAU -> JVEC and mtval is never written.
// CSR bus: csr_addr_o/csr_we_o/csr_wdata_o are decoded from the current state;
// csr_rdata_i returns the addressed CSR in the same cycle, and a write with
// csr_we_o=1 takes effect at the next rising clock edge.
module trap_ctrl_nx #(
  parameter int NUM_EXT_IRQ    = 31,
  parameter int CAUSE_EXT_BASE = 4,
  parameter int NEST_DEPTH     = 4,
  parameter int EXT_IDW        = $clog2(NUM_EXT_IRQ + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        csr_rdata_i,
  output logic [31:0]        csr_wdata_o,
  output logic               csr_we_o,
  output logic [11:0]        csr_addr_o,
  input  logic               inst_err_i,
  input  logic               mem_err_i,
  input  logic               tcmp_irq_i,
  input  logic               soft_irq_i,
  input  logic               ext_irq_valid_i,
  input  logic [EXT_IDW-1:0] ext_irq_id_i,
  output logic               ext_irq_ready_o,
  output logic               ext_cplet_o,
  output logic [EXT_IDW-1:0] ext_cplet_id_o,
  input  logic               mstatus_mie_i,
  input  logic               wfi_i,
  input  logic               mret_i,
  input  logic [31:0]        pc_i,
  input  logic [31:0]        inst_i,
  input  logic [31:0]        mem_addr_i,
  input  logic [31:0]        pc_n_i,
  output logic [31:0]        pc_n_o,
  output logic               trap_jump_o,
  output logic               trap_busy_o,
  output logic [3:0]         dbg_state_o
);

  localparam int SPW = $clog2(NEST_DEPTH + 1);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  typedef enum logic [3:0] {
    S_IDLE, S_SWFI, S_CMIE, S_WEPC, S_WCAU, S_WTVL, S_JVEC, S_MRS, S_MRJ
  } state_e;

  state_e               state_q;
  logic [31:0]          cause_q;
  logic                 is_ext_q;
  logic [SPW-1:0]       sp_q;
  logic [7:0]           miss_q;
  logic                 stk_ext_q [NEST_DEPTH];
  logic [EXT_IDW-1:0]   stk_id_q  [NEST_DEPTH];
  logic                 cplet_q;
  logic [EXT_IDW-1:0]   cplet_id_q;

  logic                 exc, irq_raw, irq, enter, stack_full, detect;
  logic [31:0]          cause_d;
  logic                 is_ext_d;
  logic                 top_ext;
  logic [EXT_IDW-1:0]   top_id;
  logic [31:0]          vec_base, jvec_pc;

  assign exc        = inst_err_i | mem_err_i;
  assign irq_raw    = ext_irq_valid_i | tcmp_irq_i | soft_irq_i;
  assign stack_full = (sp_q == SPW'(NEST_DEPTH));
  assign irq        = irq_raw & mstatus_mie_i & ~stack_full;
  assign enter      = exc | irq;
  assign detect     = enter & ((state_q == S_IDLE) | (state_q == S_SWFI));

`ifdef TRAP_MTVAL_EN
  logic [31:0] mtval_q;

  // Capture the faulting value alongside the cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mtval_q <= '0;
    else if (detect) mtval_q <= inst_err_i ? inst_i : (mem_err_i ? mem_addr_i : 32'h0);
  end
`else
  logic unused_mtval_src;
  assign unused_mtval_src = ^{inst_i, mem_addr_i};
`endif

  // Cause selection: exception over external over timer over software.
  always_comb begin
    cause_d  = 32'h0000_0001;
    is_ext_d = 1'b0;
    if (exc) begin
      cause_d = 32'h0000_0001;
    end else if (ext_irq_valid_i) begin
      cause_d  = {1'b1, 31'(ext_irq_id_i) + 31'(CAUSE_EXT_BASE)};
      is_ext_d = 1'b1;
    end else if (tcmp_irq_i) begin
      cause_d = 32'h8000_0003;
    end else if (soft_irq_i) begin
      cause_d = 32'h8000_0002;
    end
  end

  // Read the newest trap record (entry sp_q-1).
  always_comb begin
    top_ext = 1'b0;
    top_id  = '0;
    for (int i = 0; i < NEST_DEPTH; i++) begin
      if (SPW'(i + 1) == sp_q) begin
        top_ext = stk_ext_q[i];
        top_id  = stk_id_q[i];
      end
    end
  end

  // Vector target; vectored mode only offsets interrupts.
  always_comb begin
    vec_base = {csr_rdata_i[31:2], 2'b00};
    jvec_pc  = vec_base;
    if (csr_rdata_i[1:0] == 2'b01 && cause_q[31])
      jvec_pc = vec_base + {cause_q[29:0], 2'b00};
  end

  // CSR bus and redirect outputs decoded from the current state.
  always_comb begin
    csr_addr_o      = 12'h000;
    csr_we_o        = 1'b0;
    csr_wdata_o     = 32'h0;
    pc_n_o          = pc_n_i;
    trap_jump_o     = 1'b0;
    ext_irq_ready_o = 1'b0;
    case (state_q)
      S_CMIE: begin
        csr_addr_o     = CSR_MSTATUS;
        csr_we_o       = 1'b1;
        csr_wdata_o    = csr_rdata_i;
        csr_wdata_o[7] = csr_rdata_i[3];
        csr_wdata_o[3] = 1'b0;
      end
      S_WEPC: begin
        csr_addr_o  = CSR_MEPC;
        csr_we_o    = 1'b1;
        csr_wdata_o = pc_i;
      end
      S_WCAU: begin
        csr_addr_o  = CSR_MCAUSE;
        csr_we_o    = 1'b1;
        csr_wdata_o = cause_q;
      end
`ifdef TRAP_MTVAL_EN
      S_WTVL: begin
        csr_addr_o  = CSR_MTVAL;
        csr_we_o    = 1'b1;
        csr_wdata_o = mtval_q;
      end
`endif
      S_JVEC: begin
        csr_addr_o      = CSR_MTVEC;
        pc_n_o          = jvec_pc;
        trap_jump_o     = 1'b1;
        ext_irq_ready_o = is_ext_q;
      end
      S_MRS: begin
        csr_addr_o     = CSR_MSTATUS;
        csr_we_o       = 1'b1;
        csr_wdata_o    = csr_rdata_i;
        csr_wdata_o[3] = csr_rdata_i[7];
        csr_wdata_o[7] = 1'b1;
      end
      S_MRJ: begin
        csr_addr_o  = CSR_MEPC;
        pc_n_o      = csr_rdata_i & ~32'h3;
        trap_jump_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Stall while sequencing; in IDLE stall on anything about to start. Quiet in reset.
  assign trap_busy_o    = rst_n & ((state_q != S_IDLE) | enter | mret_i);
  assign ext_cplet_o    = cplet_q;
  assign ext_cplet_id_o = cplet_id_q;
  assign dbg_state_o    = state_q;

  // Trap FSM, cause latch, record stack, missed-record count, completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cause_q    <= '0;
      is_ext_q   <= 1'b0;
      sp_q       <= '0;
      miss_q     <= '0;
      cplet_q    <= 1'b0;
      cplet_id_q <= '0;
      for (int i = 0; i < NEST_DEPTH; i++) begin
        stk_ext_q[i] <= 1'b0;
        stk_id_q[i]  <= '0;
      end
    end else begin
      cplet_q <= 1'b0;
      if (detect) begin
        cause_q  <= cause_d;
        is_ext_q <= is_ext_d;
      end
      case (state_q)
        S_IDLE: begin
          if (enter)       state_q <= S_CMIE;
          else if (mret_i) state_q <= S_MRS;
          else if (wfi_i)  state_q <= S_SWFI;
        end
        S_SWFI: begin
          if (enter)                           state_q <= S_CMIE;
          else if (irq_raw && !mstatus_mie_i)  state_q <= S_IDLE;
        end
        S_CMIE: state_q <= S_WEPC;
        S_WEPC: state_q <= S_WCAU;
`ifdef TRAP_MTVAL_EN
        S_WCAU: state_q <= S_WTVL;
        S_WTVL: state_q <= S_JVEC;
`else
        S_WCAU: state_q <= S_JVEC;
`endif
        S_JVEC: begin
          // A full stack can only be entered by an exception: count it instead of pushing.
          if (stack_full) begin
            if (miss_q != 8'hFF) miss_q <= miss_q + 8'd1;
          end else begin
            for (int i = 0; i < NEST_DEPTH; i++) begin
              if (SPW'(i) == sp_q) begin
                stk_ext_q[i] <= is_ext_q;
                stk_id_q[i]  <= ext_irq_id_i;
              end
            end
            sp_q <= sp_q + SPW'(1);
          end
          state_q <= S_IDLE;
        end
        S_MRS: state_q <= S_MRJ;
        S_MRJ: begin
          // Unrecorded (missed) entries unwind first, then real records.
          if (miss_q != 8'h00) begin
            miss_q <= miss_q - 8'd1;
          end else if (sp_q != '0) begin
            sp_q <= sp_q - SPW'(1);
            if (top_ext) begin
              cplet_q    <= 1'b1;
              cplet_id_q <= top_id;
            end
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl_nx.sv
// Bench for trap_ctrl_nx: CSR file model on the one-port bus, scoreboard
// queues for redirect targets and completion IDs, directed trap scenarios.
module tb_trap_ctrl_nx;

`ifdef TRAP_MTVAL_EN
  localparam int ENTRY_LAT = 5;
`else
  localparam int ENTRY_LAT = 4;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [31:0] csr_rdata_i, csr_wdata_o;
  logic        csr_we_o;
  logic [11:0] csr_addr_o;
  logic        inst_err_i, mem_err_i, tcmp_irq_i, soft_irq_i;
  logic        ext_irq_valid_i;
  logic [4:0]  ext_irq_id_i;
  logic        ext_irq_ready_o, ext_cplet_o;
  logic [4:0]  ext_cplet_id_o;
  logic        mstatus_mie_i, wfi_i, mret_i;
  logic [31:0] pc_i, inst_i, mem_addr_i, pc_n_i, pc_n_o;
  logic        trap_jump_o, trap_busy_o;
  logic [3:0]  dbg_state;

  trap_ctrl_nx dut (
    .clk(clk), .rst_n(rst_n),
    .csr_rdata_i(csr_rdata_i), .csr_wdata_o(csr_wdata_o), .csr_we_o(csr_we_o),
    .csr_addr_o(csr_addr_o),
    .inst_err_i(inst_err_i), .mem_err_i(mem_err_i),
    .tcmp_irq_i(tcmp_irq_i), .soft_irq_i(soft_irq_i),
    .ext_irq_valid_i(ext_irq_valid_i), .ext_irq_id_i(ext_irq_id_i),
    .ext_irq_ready_o(ext_irq_ready_o), .ext_cplet_o(ext_cplet_o),
    .ext_cplet_id_o(ext_cplet_id_o),
    .mstatus_mie_i(mstatus_mie_i), .wfi_i(wfi_i), .mret_i(mret_i),
    .pc_i(pc_i), .inst_i(inst_i), .mem_addr_i(mem_addr_i),
    .pc_n_i(pc_n_i), .pc_n_o(pc_n_o),
    .trap_jump_o(trap_jump_o), .trap_busy_o(trap_busy_o),
    .dbg_state_o(dbg_state)
  );

  // ---------------- CSR file model ----------------
  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_mtval;
  logic        sw_we = 1'b0;
  logic [11:0] sw_addr = 12'h0;
  logic [31:0] sw_data = 32'h0;

  always_comb begin
    case (csr_addr_o)
      12'h300: csr_rdata_i = m_mstatus;
      12'h305: csr_rdata_i = m_mtvec;
      12'h341: csr_rdata_i = m_mepc;
      12'h342: csr_rdata_i = m_mcause;
      12'h343: csr_rdata_i = m_mtval;
      default: csr_rdata_i = 32'h0;
    endcase
  end
  assign mstatus_mie_i = m_mstatus[3];

  always @(posedge clk) begin
    logic [11:0] a;
    logic [31:0] d;
    a = csr_we_o ? csr_addr_o : sw_addr;
    d = csr_we_o ? csr_wdata_o : sw_data;
    if (csr_we_o || sw_we) begin
      case (a)
        12'h300: m_mstatus <= d;
        12'h305: m_mtvec   <= d;
        12'h341: m_mepc    <= d;
        12'h342: m_mcause  <= d;
        12'h343: m_mtval   <= d;
        default: ;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [4:0]  exp_cplet_q[$];
  int n_checks = 0, n_errors = 0;
  int n_we = 0, n_jump = 0, n_claim = 0, n_cplet = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: redirects and completions are popped against expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (csr_we_o) n_we++;
      if (ext_irq_ready_o) n_claim++;
      if (trap_jump_o) begin
        n_jump++;
        if (exp_q.size() == 0) check_eq("jump_unexpected", 32'(trap_jump_o), 32'h0);
        else check_eq("jump_pc", pc_n_o, exp_q.pop_front());
      end
      if (ext_cplet_o) begin
        n_cplet++;
        if (exp_cplet_q.size() == 0) check_eq("cplet_unexpected", 32'(ext_cplet_o), 32'h0);
        else check_eq("cplet_id", 32'(ext_cplet_id_o), 32'(exp_cplet_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic poke(input logic [11:0] a, input logic [31:0] d);
    sw_addr = a; sw_data = d; sw_we = 1'b1;
    sync();
    sw_we = 1'b0;
  endtask

  // Counts cycles after the detect cycle until the redirect strobe.
  task automatic wait_jump(input string tag, input int lat);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!trap_jump_o && k < 40);
    check_eq(tag, 32'(k), 32'(lat));
  endtask

  // Caller has set trap inputs in the detect cycle; exception inputs drop after it.
  task automatic enter(input string tag, input logic [31:0] exp_pc);
    exp_q.push_back(exp_pc);
    sync();
    inst_err_i = 1'b0; mem_err_i = 1'b0; mret_i = 1'b0;
    wait_jump(tag, ENTRY_LAT);
    sync();
  endtask

  // Returns at the negedge of the cycle after MRJ (where a completion would show).
  task automatic do_mret(input logic [31:0] ret_pc);
    exp_q.push_back(ret_pc);
    mret_i = 1'b1;
    sync();
    mret_i = 1'b0;
    wait_jump("mret_lat", 2);
    @(posedge clk); @(negedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0, j0, w0;
    rst_n = 1'b0;
    inst_err_i = 0; mem_err_i = 0; tcmp_irq_i = 0; soft_irq_i = 0;
    ext_irq_valid_i = 0; ext_irq_id_i = '0; wfi_i = 0; mret_i = 0;
    pc_i = 32'h0; inst_i = 32'h0; mem_addr_i = 32'h0; pc_n_i = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_we", 32'(csr_we_o), 32'h0);
    check_eq("rst_addr", 32'(csr_addr_o), 32'h0);
    check_eq("rst_jump", 32'(trap_jump_o), 32'h0);
    check_eq("rst_busy", 32'(trap_busy_o), 32'h0);
    check_eq("rst_ready", 32'(ext_irq_ready_o), 32'h0);
    check_eq("rst_cplet", 32'(ext_cplet_o), 32'h0);
    check_eq("rst_pc_n", pc_n_o, 32'h1234_5678);
    poke(12'h300, 32'h8); poke(12'h305, 32'h0000_1000);
    poke(12'h341, 32'h0); poke(12'h342, 32'h0); poke(12'h343, 32'h0);
    rst_n = 1'b1;
    sync();

    // Illegal instruction (with a simultaneous MRET that must lose), direct mtvec.
    pc_i = 32'h100; inst_i = 32'hFFFF_FFFF; inst_err_i = 1'b1; mret_i = 1'b1;
    @(negedge clk);
    check_eq("exc_busy", 32'(trap_busy_o), 32'h1);
    enter("exc_lat", 32'h0000_1000);
    check_eq("exc_mepc", m_mepc, 32'h100);
    check_eq("exc_mcause", m_mcause, 32'h1);
`ifdef TRAP_MTVAL_EN
    check_eq("exc_mtval", m_mtval, 32'hFFFF_FFFF);
`endif
    check_eq("exc_mstatus", m_mstatus, 32'h80);
    do_mret(32'h100);
    sync();
    check_eq("mret_mstatus", m_mstatus, 32'h88);

    // External ID 5, vectored mtvec.
    poke(12'h305, 32'h8000_0001);
    c0 = n_claim;
    pc_i = 32'h204; ext_irq_valid_i = 1'b1; ext_irq_id_i = 5'd5;
    enter("ext_lat", 32'h8000_0024);
    ext_irq_valid_i = 1'b0;
    check_eq("ext_mcause", m_mcause, 32'h8000_0009);
    check_eq("ext_mepc", m_mepc, 32'h204);
    check_eq("ext_claims", 32'(n_claim - c0), 32'h1);
`ifdef TRAP_MTVAL_EN
    check_eq("ext_mtval", m_mtval, 32'h0);
`endif
    exp_cplet_q.push_back(5'd5);
    c0 = n_cplet;
    do_mret(32'h204);
    check_eq("ext_cplet_cnt", 32'(n_cplet - c0), 32'h1);
    sync();

    // External + timer + software together: external first, timer after MRET.
    pc_i = 32'h208; ext_irq_valid_i = 1'b1; ext_irq_id_i = 5'd5;
    tcmp_irq_i = 1'b1; soft_irq_i = 1'b1;
    enter("mix_lat", 32'h8000_0024);
    ext_irq_valid_i = 1'b0;
    check_eq("mix_mcause", m_mcause, 32'h8000_0009);
    exp_cplet_q.push_back(5'd5);
    c0 = n_cplet;
    do_mret(32'h208);
    exp_q.push_back(32'h8000_000C);
    wait_jump("timer_lat", ENTRY_LAT);
    sync();
    tcmp_irq_i = 1'b0; soft_irq_i = 1'b0;
    check_eq("timer_mcause", m_mcause, 32'h8000_0003);
    check_eq("mix_cplet_cnt", 32'(n_cplet - c0), 32'h1);
    do_mret(32'h208);
    sync();

    // WFI with MIE=0: timer wakes to IDLE without any trap activity.
    poke(12'h300, 32'h0);
    w0 = n_we; j0 = n_jump;
    wfi_i = 1'b1;
    sync();
    wfi_i = 1'b0;
    @(negedge clk);
    check_eq("wfi_busy", 32'(trap_busy_o), 32'h1);
    sync();
    tcmp_irq_i = 1'b1;
    repeat (4) sync();
    @(negedge clk);
    check_eq("wfi_exit_busy", 32'(trap_busy_o), 32'h0);
    check_eq("wfi_writes", 32'(n_we - w0), 32'h0);
    check_eq("wfi_jumps", 32'(n_jump - j0), 32'h0);
    sync();
    tcmp_irq_i = 1'b0;

    // Fill the 4-deep record stack, then a masked interrupt and an exception overflow.
    c0 = n_claim;
    poke(12'h300, 32'h8);
    pc_i = 32'h300; ext_irq_valid_i = 1'b1; ext_irq_id_i = 5'd3;
    enter("nest1_lat", 32'h8000_001C);
    ext_irq_valid_i = 1'b0;
    poke(12'h300, 32'h8);
    tcmp_irq_i = 1'b1;
    enter("nest2_lat", 32'h8000_000C);
    tcmp_irq_i = 1'b0;
    poke(12'h300, 32'h8);
    soft_irq_i = 1'b1;
    enter("nest3_lat", 32'h8000_0008);
    soft_irq_i = 1'b0;
    poke(12'h300, 32'h8);
    ext_irq_valid_i = 1'b1; ext_irq_id_i = 5'd7;
    enter("nest4_lat", 32'h8000_002C);
    ext_irq_valid_i = 1'b0;
    check_eq("nest_claims", 32'(n_claim - c0), 32'h2);
    poke(12'h300, 32'h8);
    tcmp_irq_i = 1'b1;
    j0 = n_jump;
    repeat (6) sync();
    @(negedge clk);
    check_eq("full_mask_busy", 32'(trap_busy_o), 32'h0);
    check_eq("full_mask_jumps", 32'(n_jump - j0), 32'h0);
    sync();
    pc_i = 32'h500; inst_i = 32'h13; inst_err_i = 1'b1;
    enter("full_exc_lat", 32'h8000_0000);
    tcmp_irq_i = 1'b0;
    check_eq("full_exc_mcause", m_mcause, 32'h1);
    check_eq("full_claims", 32'(n_claim - c0), 32'h2);
    exp_cplet_q.push_back(5'd7);
    exp_cplet_q.push_back(5'd3);
    c0 = n_cplet;
    do_mret(32'h500);
    check_eq("miss_mret_cplet", 32'(n_cplet - c0), 32'h0);
    sync();
    do_mret(32'h500);
    check_eq("pop4_cplet", 32'(n_cplet - c0), 32'h1);
    sync();
    do_mret(32'h500); sync();
    do_mret(32'h500); sync();
    do_mret(32'h500);
    check_eq("pop1_cplet", 32'(n_cplet - c0), 32'h2);
    sync();
    do_mret(32'h500);
    check_eq("empty_mret_cplet", 32'(n_cplet - c0), 32'h2);
    sync();

    // Reset asserted in WCAU: outputs drop at once, no jump afterwards.
    poke(12'h342, 32'hDEAD_BEEF);
    j0 = n_jump;
    pc_i = 32'h600; inst_err_i = 1'b1;
    sync();
    inst_err_i = 1'b0;
    sync();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_we", 32'(csr_we_o), 32'h0);
    check_eq("mid_rst_addr", 32'(csr_addr_o), 32'h0);
    check_eq("mid_rst_wdata", csr_wdata_o, 32'h0);
    check_eq("mid_rst_jump", 32'(trap_jump_o), 32'h0);
    check_eq("mid_rst_busy", 32'(trap_busy_o), 32'h0);
    check_eq("mid_rst_ready", 32'(ext_irq_ready_o), 32'h0);
    check_eq("mid_rst_pc_n", pc_n_o, 32'h1234_5678);
    sync();
    rst_n = 1'b1;
    repeat (10) sync();
    check_eq("mid_rst_mcause", m_mcause, 32'hDEAD_BEEF);
    check_eq("mid_rst_jumps", 32'(n_jump - j0), 32'h0);
    poke(12'h341, 32'h702);
    c0 = n_cplet;
    do_mret(32'h700);
    check_eq("post_rst_cplet", 32'(n_cplet - c0), 32'h0);
    sync();

    check_eq("jump_q_empty", 32'(exp_q.size()), 32'h0);
    check_eq("cplet_q_empty", 32'(exp_cplet_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog: the scenario above is a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
